// File: rtl/parking_pkg.sv
// Shared constants and helpers for the parking occupancy path.
// Used by the counter, the display mux and the gate controller.
package parking_pkg;

  localparam int BCD_DIGITS   = 4;
  localparam int BCD_W        = 4 * BCD_DIGITS;
  localparam int CAPACITY_DEF = 150;
  localparam int DEBOUNCE_DEF = 4;

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int               t;
    r = '0;
    t = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/parking_occupancy_counter_if.sv
// Sensor/control inputs and count/status outputs of the occupancy counter.
// master drives the sensors, slave is the counter.
interface parking_occupancy_counter_if;
  import parking_pkg::*;

  logic             enter_sensor;
  logic             exit_sensor;
  logic             clear;
  logic [BCD_W-1:0] bcd_out;
  logic             full;
  logic             empty;
  logic             entry_grant;
  logic             entry_reject;
  logic             exit_grant;
  logic             exit_reject;

  modport master (
    output enter_sensor, exit_sensor, clear,
    input  bcd_out, full, empty,
    input  entry_grant, entry_reject,
    input  exit_grant, exit_reject
  );

  modport slave (
    input  enter_sensor, exit_sensor, clear,
    output bcd_out, full, empty,
    output entry_grant, entry_reject,
    output exit_grant, exit_reject
  );

endinterface

// File: rtl/bcd_digit_updown.sv
// One BCD digit with increment/decrement and carry/borrow ripple.
// cin/bin enable the step; cout/bout pass the wrap to the next digit.
module bcd_digit_updown (
  input  logic [3:0] d,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] q,
  output logic       cout,
  output logic       bout
);

  // next digit value and wrap flags
  always_comb begin
    q    = d;
    cout = 1'b0;
    bout = 1'b0;
    if (inc && cin) begin
      if (d == 4'd9) begin
        q    = 4'd0;
        cout = 1'b1;
      end else begin
        q = d + 4'd1;
      end
    end else if (dec && bin) begin
      if (d == 4'd0) begin
        q    = 4'd9;
        bout = 1'b1;
      end else begin
        q = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/parking_occupancy_counter.sv
// Occupied-space counter in packed BCD, fed by debounced gate sensors.
// Registers count, full/empty and per-gate grant/reject pulses.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  parking_occupancy_counter_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [BCD_W-1:0] CAP_BCD = to_bcd(CAPACITY);

  // bit 0 = entry gate, bit 1 = exit gate
  logic [1:0]      raw;
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      filt;
  logic [1:0]      filt_d;
  logic [DB_W-1:0] cnt [2];
  logic [1:0]      ev;

  assign raw = {bus.exit_sensor, bus.enter_sensor};
  assign ev  = filt & ~filt_d;

  // synchronise and debounce both sensors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= '0;
      s2     <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic [BCD_W-1:0] bcd_q;
  logic             full_q;
  logic             empty_q;
  logic             inc_en;
  logic             dec_en;
  logic             eg_n;
  logic             er_n;
  logic             xg_n;
  logic             xr_n;

  // per-cycle decision: which gate is granted and which way to count
  always_comb begin
    inc_en = 1'b0;
    dec_en = 1'b0;
    eg_n   = 1'b0;
    er_n   = 1'b0;
    xg_n   = 1'b0;
    xr_n   = 1'b0;
    if (!bus.clear) begin
      unique case (1'b1)
        ev[0] && ev[1]: begin
          eg_n = 1'b1;
          if (empty_q) begin
            inc_en = 1'b1;
            xr_n   = 1'b1;
          end else begin
            xg_n = 1'b1;
          end
        end
        ev[0] && !ev[1]: begin
          if (full_q) begin
            er_n = 1'b1;
          end else begin
            inc_en = 1'b1;
            eg_n   = 1'b1;
          end
        end
        !ev[0] && ev[1]: begin
          if (empty_q) begin
            xr_n = 1'b1;
          end else begin
            dec_en = 1'b1;
            xg_n   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [BCD_DIGITS:0] cy;
  logic [BCD_DIGITS:0] bw;
  logic [BCD_W-1:0]    bcd_n;
  logic                unused_wrap;

  assign cy[0]       = 1'b1;
  assign bw[0]       = 1'b1;
  assign unused_wrap = cy[BCD_DIGITS] | bw[BCD_DIGITS];

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
    bcd_digit_updown u_dig (
      .d    (bcd_q[4*g +: 4]),
      .inc  (inc_en),
      .dec  (dec_en),
      .cin  (cy[g]),
      .bin  (bw[g]),
      .q    (bcd_n[4*g +: 4]),
      .cout (cy[g+1]),
      .bout (bw[g+1])
    );
  end

  // count, flags and pulses; clear wins over any event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q            <= '0;
      full_q           <= 1'b0;
      empty_q          <= 1'b1;
      bus.entry_grant  <= 1'b0;
      bus.entry_reject <= 1'b0;
      bus.exit_grant   <= 1'b0;
      bus.exit_reject  <= 1'b0;
    end else begin
      bcd_q            <= bus.clear ? '0 : bcd_n;
      full_q           <= !bus.clear && (bcd_n == CAP_BCD);
      empty_q          <= bus.clear || (bcd_n == '0);
      bus.entry_grant  <= eg_n;
      bus.entry_reject <= er_n;
      bus.exit_grant   <= xg_n;
      bus.exit_reject  <= xr_n;
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.full    = full_q;
  assign bus.empty   = empty_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench for the parking occupancy counter.
// DEBOUNCE=4, CAPACITY=150.
module tb_parking_occupancy_counter;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   pulse_cnt = 0;
  logic [3:0] p;
  int   pc0;

  parking_occupancy_counter_if bus ();

  parking_occupancy_counter #(
    .CAPACITY (150),
    .DEBOUNCE (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.entry_grant | bus.entry_reject |
        bus.exit_grant | bus.exit_reject)
      pulse_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one car: sensors high 10 cycles, low 10; p sampled on the update edge
  // p = {entry_grant, entry_reject, exit_grant, exit_reject}
  task automatic car(input logic en, input logic ex,
                     output logic [3:0] po);
    bus.enter_sensor = en;
    bus.exit_sensor  = ex;
    step(7);
    po = {bus.entry_grant, bus.entry_reject,
          bus.exit_grant, bus.exit_reject};
    step(3);
    bus.enter_sensor = 1'b0;
    bus.exit_sensor  = 1'b0;
    step(10);
  endtask

  initial begin
    bus.enter_sensor = 1'b0;
    bus.exit_sensor  = 1'b0;
    bus.clear        = 1'b0;
    step(3);
    chk("rst_bcd", bus.bcd_out, 16'h0000);
    chk("rst_flags", {14'd0, bus.full, bus.empty}, 16'h0001);
    chk("rst_pulses", {12'd0, bus.entry_grant, bus.entry_reject,
                       bus.exit_grant, bus.exit_reject}, 16'h0000);
    reset = 1'b1;
    step(2);

    // 1: clean entry, exact latency
    bus.enter_sensor = 1'b1;
    step(6);
    chk("t1_before", bus.bcd_out, 16'h0000);
    chk("t1_no_grant_yet", {15'd0, bus.entry_grant}, 16'h0000);
    step(1);
    chk("t1_bcd", bus.bcd_out, 16'h0001);
    chk("t1_grant", {15'd0, bus.entry_grant}, 16'h0001);
    chk("t1_empty", {15'd0, bus.empty}, 16'h0000);
    step(1);
    chk("t1_grant_1cyc", {15'd0, bus.entry_grant}, 16'h0000);
    step(2);
    bus.enter_sensor = 1'b0;
    step(10);
    car(1'b0, 1'b1, p);
    chk("t1_exit_pulse", {12'd0, p}, 16'h0002);
    chk("t1_back_empty", {15'd0, bus.empty}, 16'h0001);

    // 2: short glitch is filtered
    pc0 = pulse_cnt;
    bus.enter_sensor = 1'b1;
    step(2);
    bus.enter_sensor = 1'b0;
    step(12);
    chk("t2_bcd", bus.bcd_out, 16'h0000);
    chk("t2_no_pulse", 16'(pulse_cnt - pc0), 16'h0000);

    // 3: carry and borrow across digits
    repeat (99) car(1'b1, 1'b0, p);
    chk("t3_99", bus.bcd_out, 16'h0099);
    car(1'b1, 1'b0, p);
    chk("t3_inc_pulse", {12'd0, p}, 16'h0008);
    chk("t3_100", bus.bcd_out, 16'h0100);
    car(1'b0, 1'b1, p);
    chk("t3_dec_pulse", {12'd0, p}, 16'h0002);
    chk("t3_099", bus.bcd_out, 16'h0099);

    // 4: fill to capacity, then reject
    repeat (51) car(1'b1, 1'b0, p);
    chk("t4_150", bus.bcd_out, 16'h0150);
    chk("t4_full", {15'd0, bus.full}, 16'h0001);
    car(1'b1, 1'b0, p);
    chk("t4_reject", {12'd0, p}, 16'h0004);
    chk("t4_still_150", bus.bcd_out, 16'h0150);
    chk("t4_still_full", {15'd0, bus.full}, 16'h0001);
    car(1'b1, 1'b1, p);
    chk("t4_both_full", {12'd0, p}, 16'h000a);
    chk("t4_both_full_bcd", bus.bcd_out, 16'h0150);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk("t4_clear", bus.bcd_out, 16'h0000);
    chk("t4_clear_flags", {14'd0, bus.full, bus.empty}, 16'h0001);

    // 5: simultaneous entry+exit on empty lot, then mid-count
    car(1'b1, 1'b1, p);
    chk("t5_pulses", {12'd0, p}, 16'h0009);
    chk("t5_bcd", bus.bcd_out, 16'h0001);
    car(1'b1, 1'b1, p);
    chk("t5_mid_pulses", {12'd0, p}, 16'h000a);
    chk("t5_mid_bcd", bus.bcd_out, 16'h0001);

    // 6: clear during debounce, then async reset mid-debounce
    repeat (41) car(1'b1, 1'b0, p);
    chk("t6_42", bus.bcd_out, 16'h0042);
    pc0 = pulse_cnt;
    bus.enter_sensor = 1'b1;
    step(3);
    bus.clear = 1'b1;
    step(6);
    bus.clear = 1'b0;
    step(1);
    chk("t6_clr_bcd", bus.bcd_out, 16'h0000);
    chk("t6_clr_empty", {15'd0, bus.empty}, 16'h0001);
    chk("t6_clr_no_grant", 16'(pulse_cnt - pc0), 16'h0000);
    step(2);
    bus.enter_sensor = 1'b0;
    step(12);
    car(1'b1, 1'b0, p);
    chk("t6_one", bus.bcd_out, 16'h0001);
    bus.enter_sensor = 1'b1;
    step(3);
    reset = 1'b0;
    #1;
    chk("t6_rst_bcd", bus.bcd_out, 16'h0000);
    chk("t6_rst_flags", {14'd0, bus.full, bus.empty}, 16'h0001);
    step(2);
    reset = 1'b1;
    step(6);
    chk("t6_held_wait", bus.bcd_out, 16'h0000);
    step(1);
    chk("t6_held_bcd", bus.bcd_out, 16'h0001);
    chk("t6_held_grant", {15'd0, bus.entry_grant}, 16'h0001);
    bus.enter_sensor = 1'b0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
